// File: rtl/cross_corr_pkg.sv
// Shared definitions for the cross-correlation control block: register map,
// bit positions, AXI response codes and the read-channel state type.
package cross_corr_pkg;

  localparam int unsigned OFF_CTRL   = 32'h00;
  localparam int unsigned OFF_STATUS = 32'h04;
  localparam int unsigned OFF_CFG0   = 32'h08;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STAT_READY_BIT  = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_ERR_BIT    = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/cross_corr_ctrl.sv
// AXI4-Lite register front end for a cross-correlation core: start/irq control,
// sticky status and a bank of configuration fields driven onto cfg_o.
module cross_corr_ctrl
  import cross_corr_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5,
  parameter int NUM_CFG_G            = 4,
  parameter int CFG_WIDTH_G          = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic                                start_o,
  input  logic                                ready_i,
  input  logic                                done_i,
  output logic [NUM_CFG_G*CFG_WIDTH_G-1:0]    cfg_o,
  output logic                                irq_o,
  output r_state_e                            rd_state_o
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int unsigned NCFG    = NUM_CFG_G;
  localparam int unsigned W_CTRL  = OFF_CTRL >> 2;
  localparam int unsigned W_STAT  = OFF_STATUS >> 2;
  localparam int unsigned W_CFG0  = OFF_CFG0 >> 2;

  // Handshakes: a transfer on any channel happens on the rising edge where its
  // valid and ready are both 1; valid never depends on ready combinationally.
  logic                              alive_q, alive_d;
  logic                              aw_full_q, aw_full_d;
  logic [AW-1:0]                     aw_addr_q, aw_addr_d;
  logic                              w_full_q, w_full_d;
  logic [DW-1:0]                     w_data_q, w_data_d;
  logic [SW-1:0]                     w_strb_q, w_strb_d;
  logic                              bvalid_q, bvalid_d;
  logic [1:0]                        bresp_q, bresp_d;
  r_state_e                          r_state_q, r_state_d;
  logic [DW-1:0]                     rdata_q, rdata_d;
  logic [1:0]                        rresp_q, rresp_d;
  logic                              irq_en_q, irq_en_d;
  logic                              done_q, done_d;
  logic                              err_q, err_d;
  logic                              start_q, start_d;
  logic                              irq_q, irq_d;
  logic [NUM_CFG_G-1:0][CFG_WIDTH_G-1:0] cfg_q, cfg_d;

  logic              commit;
  int unsigned       wr_word, rd_word;
  logic [DW-1:0]     rd_data;
  logic              rd_hit;

  function automatic int unsigned word_idx(input logic [AW-1:0] a);
    return 32'(a[AW-1:2]);
  endfunction

  assign s00_axi_awready = alive_q & ~aw_full_q;
  assign s00_axi_wready  = alive_q & ~w_full_q;
  assign s00_axi_arready = alive_q & (r_state_q == R_IDLE);
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_rvalid  = (r_state_q == R_DATA);
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign start_o         = start_q;
  assign irq_o           = irq_q;
  assign cfg_o           = cfg_q;
  assign rd_state_o      = r_state_q;

  assign commit  = aw_full_q & w_full_q & ~bvalid_q;
  assign wr_word = word_idx(aw_addr_q);
  assign rd_word = word_idx(s00_axi_araddr);

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    if (rd_word == W_CTRL) begin
      rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
    end else if (rd_word == W_STAT) begin
      rd_data[STAT_READY_BIT] = ready_i;
      rd_data[STAT_DONE_BIT]  = done_q;
      rd_data[STAT_ERR_BIT]   = err_q;
    end else if (rd_word >= W_CFG0 && rd_word < W_CFG0 + NCFG) begin
      for (int unsigned k = 0; k < NCFG; k++) begin
        if (rd_word == W_CFG0 + k) rd_data[CFG_WIDTH_G-1:0] = cfg_q[k];
      end
    end else begin
      rd_hit = 1'b0;
    end
  end

  always_comb begin
    alive_d   = 1'b1;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    err_d     = err_q;
    cfg_d     = cfg_q;
    start_d   = 1'b0;

    if (s00_axi_awvalid && s00_axi_awready) begin
      aw_full_d = 1'b1;
      aw_addr_d = s00_axi_awaddr;
    end
    if (s00_axi_wvalid && s00_axi_wready) begin
      w_full_d = 1'b1;
      w_data_d = s00_axi_wdata;
      w_strb_d = s00_axi_wstrb;
    end
    if (bvalid_q && s00_axi_bready) bvalid_d = 1'b0;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (wr_word < W_CFG0 + NCFG) ? RESP_OKAY : RESP_SLVERR;
      if (wr_word == W_CTRL && w_strb_q[0]) begin
        irq_en_d = w_data_q[CTRL_IRQ_EN_BIT];
        // A start request while the core is busy is refused and flagged.
        if (w_data_q[CTRL_START_BIT]) begin
          if (ready_i) start_d = 1'b1;
          else         err_d   = 1'b1;
        end
      end
      if (wr_word == W_STAT && w_strb_q[0]) begin
        if (w_data_q[STAT_DONE_BIT]) done_d = 1'b0;
        if (w_data_q[STAT_ERR_BIT])  err_d  = 1'b0;
      end
      for (int unsigned k = 0; k < NCFG; k++) begin
        if (wr_word == W_CFG0 + k) begin
          for (int i = 0; i < CFG_WIDTH_G; i++) begin
            if (w_strb_q[i/8]) cfg_d[k][i] = w_data_q[i];
          end
        end
      end
    end

    // A completion arriving alongside a W1C must not be lost.
    if (done_i) done_d = 1'b1;
    irq_d = done_q & irq_en_q;
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s00_axi_arvalid && s00_axi_arready) begin
          r_state_d = R_DATA;
          rdata_d   = rd_data;
          rresp_d   = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q   <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
      cfg_q     <= '0;
    end else begin
      alive_q   <= alive_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
      cfg_q     <= cfg_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, aw_addr_q[1:0],
                       s00_axi_araddr[1:0], w_data_q, w_strb_q};

endmodule

// File: tb/tb_cross_corr_ctrl.sv
// Self-checking bench for cross_corr_ctrl: AXI4-Lite register traffic with
// response scoreboards, start/irq/done behaviour and reset mid-transaction.
module tb_cross_corr_ctrl;
  import cross_corr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        start_o, ready_i, done_i, irq_o;
  logic [63:0] cfg_o;
  r_state_e    rd_state;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  logic b_start_seen, b_irq_seen;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [15:0] cfg_m[4];

  always #5 clk = ~clk;

  cross_corr_ctrl dut (
    .clk(clk), .rst(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .start_o(start_o), .ready_i(ready_i), .done_i(done_i),
    .cfg_o(cfg_o), .irq_o(irq_o), .rd_state_o(rd_state)
  );

  always @(negedge clk) if (start_o) start_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_b(input string tag);
    int t = 0;
    logic [1:0] e;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    if (!bvalid) begin
      check_eq({tag, "_b_timeout"}, 64'd0, 64'd1);
      if (exp_b_q.size() > 0) void'(exp_b_q.pop_front());
      return;
    end
    e = exp_b_q.pop_front();
    check_eq({tag, "_bresp"}, 64'(bresp), 64'(e));
    b_start_seen = start_o;
    b_irq_seen   = irq_o;
    @(negedge clk);
  endtask

  task automatic axi_write(input string tag, input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_lead,
                           input logic [1:0] exp_resp, input logic done_at_commit);
    int t = 0;
    logic w_started = 1'b0;
    logic aw_hs, w_hs;
    exp_b_q.push_back(exp_resp);
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1;
    if (aw_lead == 0) begin wdata = data; wstrb = strb; wvalid = 1'b1; w_started = 1'b1; end
    while ((awvalid || wvalid || !w_started) && t < 100) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk); t++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      if (!w_started && t >= aw_lead) begin
        wdata = data; wstrb = strb; wvalid = 1'b1; w_started = 1'b1;
      end
    end
    if (awvalid || wvalid) begin
      check_eq({tag, "_hs_timeout"}, 64'd0, 64'd1);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    if (done_at_commit) begin
      done_i = 1'b1;
      @(negedge clk);
      done_i = 1'b0;
    end
    wait_b(tag);
  endtask

  task automatic axi_read(input string tag, input logic [4:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int t = 0;
    logic [33:0] e;
    exp_r_q.push_back({exp_resp, exp_data});
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    arvalid = 1'b0;
    check_eq({tag, "_rlat"}, 64'(rvalid), 64'd1);
    t = 0;
    while (!rvalid && t < 50) begin @(negedge clk); t++; end
    if (!rvalid) begin
      check_eq({tag, "_r_timeout"}, 64'd0, 64'd1);
      void'(exp_r_q.pop_front());
      return;
    end
    e = exp_r_q.pop_front();
    check_eq({tag, "_rdata"}, 64'(rdata), 64'(e[31:0]));
    check_eq({tag, "_rresp"}, 64'(rresp), 64'(e[33:32]));
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int t;
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
    ready_i = 1'b1; done_i = 1'b0;
    for (int k = 0; k < 4; k++) cfg_m[k] = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_awready", 64'(awready), 64'd0);
    check_eq("rst_wready",  64'(wready),  64'd0);
    check_eq("rst_arready", 64'(arready), 64'd0);
    check_eq("rst_valids",  64'({bvalid, rvalid}), 64'd0);
    check_eq("rst_start_irq", 64'({start_o, irq_o}), 64'd0);
    check_eq("rst_cfg", cfg_o, 64'd0);
    check_eq("rst_rstate", 64'(rd_state), 64'(R_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_readies", 64'({awready, wready, arready}), 64'h7);

    // Basic CFG write/readback
    axi_write("cfg0_wr", 5'h08, 32'h0000_00A0, 4'hF, 0, RESP_OKAY, 1'b0);
    cfg_m[0] = 16'h00A0;
    check_eq("cfg0_out", 64'(cfg_o[15:0]), 64'h00A0);
    axi_read("cfg0_rd", 5'h08, 32'h0000_00A0, RESP_OKAY);

    // Byte strobes on CFG1
    axi_write("cfg1_b0", 5'h0C, 32'h0000_BEEF, 4'h1, 1, RESP_OKAY, 1'b0);
    axi_read("cfg1_b0_rd", 5'h0C, 32'h0000_00EF, RESP_OKAY);
    axi_write("cfg1_b1", 5'h0D, 32'h0000_1234, 4'h2, 0, RESP_OKAY, 1'b0);
    cfg_m[1] = 16'h12EF;
    axi_read("cfg1_b1_rd", 5'h0E, 32'h0000_12EF, RESP_OKAY);

    // Random full-word writes to CFG2..3, upper bits must read back as zero
    for (int k = 2; k < 4; k++) begin
      v = $urandom();
      axi_write("cfg_rand_wr", 5'(8 + 4*k), v, 4'hF, int'($urandom_range(0, 4)), RESP_OKAY, 1'b0);
      cfg_m[k] = v[15:0];
      check_eq("cfg_rand_out", 64'(cfg_o[k*16 +: 16]), 64'(cfg_m[k]));
      axi_read("cfg_rand_rd", 5'(8 + 4*k), {16'h0, cfg_m[k]}, RESP_OKAY);
    end

    // START accepted with AW presented three cycles ahead of W
    ready_i = 1'b1; start_cnt = 0;
    axi_write("start_ok", 5'h00, 32'h1, 4'hF, 3, RESP_OKAY, 1'b0);
    check_eq("start_with_b", 64'(b_start_seen), 64'd1);
    repeat (3) @(negedge clk);
    check_eq("start_count", 64'(start_cnt), 64'd1);
    axi_read("ctrl_rd", 5'h00, 32'h0, RESP_OKAY);

    // START refused while busy
    ready_i = 1'b0; start_cnt = 0;
    axi_write("start_busy", 5'h00, 32'h1, 4'hF, 0, RESP_OKAY, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("start_busy_count", 64'(start_cnt), 64'd0);
    axi_read("status_err", 5'h04, 32'h4, RESP_OKAY);
    axi_write("err_w1c", 5'h04, 32'h4, 4'h1, 0, RESP_OKAY, 1'b0);
    axi_read("status_clr", 5'h04, 32'h0, RESP_OKAY);
    ready_i = 1'b1;

    // IRQ, sticky DONE, set-wins-over-clear
    axi_write("irq_en", 5'h00, 32'h2, 4'hF, 0, RESP_OKAY, 1'b0);
    check_eq("irq_before_done", 64'(irq_o), 64'd0);
    @(negedge clk); done_i = 1'b1;
    @(negedge clk); done_i = 1'b0;
    @(negedge clk);
    check_eq("irq_after_done", 64'(irq_o), 64'd1);
    axi_read("status_done", 5'h04, 32'h3, RESP_OKAY);
    axi_write("w1c_vs_done", 5'h04, 32'h2, 4'hF, 0, RESP_OKAY, 1'b1);
    check_eq("irq_hold_b", 64'(b_irq_seen), 64'd1);
    repeat (2) @(negedge clk);
    check_eq("irq_hold", 64'(irq_o), 64'd1);
    axi_read("status_done_kept", 5'h04, 32'h3, RESP_OKAY);
    axi_write("w1c_nostrb", 5'h04, 32'h2, 4'h2, 0, RESP_OKAY, 1'b0);
    axi_read("status_nostrb", 5'h04, 32'h3, RESP_OKAY);
    axi_write("w1c_done", 5'h04, 32'h2, 4'h1, 0, RESP_OKAY, 1'b0);
    check_eq("irq_at_b", 64'(b_irq_seen), 64'd1);
    check_eq("irq_dropped", 64'(irq_o), 64'd0);

    // Unmapped offset
    axi_write("unmapped_wr", 5'h1C, 32'hFFFF_FFFF, 4'hF, 0, RESP_SLVERR, 1'b0);
    check_eq("unmapped_cfg", cfg_o, {cfg_m[3], cfg_m[2], cfg_m[1], cfg_m[0]});
    axi_read("unmapped_ctrl", 5'h00, 32'h2, RESP_OKAY);
    axi_read("unmapped_rd", 5'h1C, 32'h0, RESP_SLVERR);

    // Reset with AW latched but W not yet sent
    start_cnt = 0;
    @(negedge clk);
    awaddr = 5'h00; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    awvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("midrst_bvalid", 64'(bvalid), 64'd0);
    check_eq("midrst_readies", 64'({awready, wready, arready}), 64'd0);
    check_eq("midrst_cfg", cfg_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) axi_read("post_rst_cfg", 5'(8 + 4*k), 32'h0, RESP_OKAY);
    axi_read("post_rst_ctrl", 5'h00, 32'h0, RESP_OKAY);
    @(negedge clk);
    wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    t = 0;
    while (!wready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    wvalid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("lone_w_no_b", 64'(bvalid), 64'd0);
    exp_b_q.push_back(RESP_OKAY);
    awaddr = 5'h10; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    awvalid = 1'b0;
    wait_b("late_aw");
    repeat (2) @(negedge clk);
    check_eq("midrst_no_start", 64'(start_cnt), 64'd0);
    axi_read("late_aw_cfg2", 5'h10, 32'h1, RESP_OKAY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
